tx_ffe_tuner: RTL and testbench
===============================

// Module: tx_ffe_tuner
// PURPOSE
//  Sequencer that selects the TX FFE tap setting driven into the tx_ffe tx_setting input.
//  Sweeps every setting, holds each one for a settle window, then counts receiver error
//  strobes (PRBS checker) over a fixed dwell window. Applies the setting with fewest errors.
//  Sits beside tx_ffe in the TX path; also offers a manual override for lab/bench use.
// PARAMETERS
//  TX_SETTING_WIDTH  4     width of tx_setting (matches tx_package value)
//  N_SETTINGS        16    settings swept, 0..N_SETTINGS-1; 2 <= N_SETTINGS <= 2**TX_SETTING_WIDTH
//  SETTLE_CYCLES     64    cycles per setting before counting starts (>=1)
//  DWELL_CYCLES      1024  cycles per setting during which err is counted (>=1)
//  ERR_CNT_WIDTH     16    error counter width; counter saturates at all-ones
// PORTS
//  clk             in   1                  clock, same domain as tx_ffe
//  rst             in   1                  synchronous reset, active-high
//  start           in   1                  level/pulse; begins sweep when sampled in IDLE or DONE
//  manual_en       in   1                  1 = drive manual_setting instead of tuned value
//  manual_setting  in   TX_SETTING_WIDTH   override value
//  err             in   1                  one error per cycle when high (checker strobe)
//  tx_setting      out  TX_SETTING_WIDTH   registered; to tx_ffe.tx_setting
//  busy            out  1                  high in SETTLE/MEASURE/COMPARE/APPLY
//  done            out  1                  high in DONE only
//  best_setting    out  TX_SETTING_WIDTH   winning setting of most recent sweep
//  best_err_count  out  ERR_CNT_WIDTH      error count of best_setting
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE, tx_setting=0, busy=0, done=0, best_setting=0,
//   best_err_count=all-ones, all counters 0. rst mid-sweep aborts immediately, same values.
//  States: IDLE, SETTLE, MEASURE, COMPARE, APPLY, DONE. All outputs registered.
//  IDLE/DONE: start=1 and manual_en=0 -> SETTLE next cycle; cur_setting=0, tx_setting=0,
//   best_err_count=all-ones, best_setting=0, done=0, busy=1. start with manual_en=1: ignored.
//  start while busy=1: ignored (no restart).
//  SETTLE: exactly SETTLE_CYCLES cycles, err ignored, then MEASURE with err_cnt=0.
//  MEASURE: exactly DWELL_CYCLES cycles; err_cnt += err each cycle, saturating at all-ones.
//  COMPARE (1 cycle): if err_cnt < best_err_count (strict) update best_* with cur_setting and
//   err_cnt; ties keep lower setting. First setting always wins vs all-ones unless saturated;
//   if every setting saturates best_setting stays 0. Then if cur_setting==N_SETTINGS-1 ->
//   APPLY, else cur_setting+1, tx_setting updates same edge, -> SETTLE.
//  APPLY (1 cycle): tx_setting <= best_setting; -> DONE. DONE holds until start or rst.
//  Sweep latency: start sampled at edge 0 -> done=1 after N_SETTINGS*(SETTLE_CYCLES+
//   DWELL_CYCLES+1)+1 edges.
//  manual_en=1 in IDLE/DONE: tx_setting <= manual_setting each cycle (1-cycle latency);
//   dropping manual_en in DONE restores best_setting next cycle, in IDLE holds last value.
//   manual_en asserted while busy is ignored until sweep completes.
//  tx_setting changes only on state transitions listed above (tx_ffe ROM address stable
//   during each MEASURE window).
// TESTING  (bench params: N_SETTINGS=4, SETTLE_CYCLES=2, DWELL_CYCLES=8, ERR_CNT_WIDTH=4)
//  1 rst, 1-cycle start, err count per setting {5,2,7,3} -> tx_setting steps 0,1,2,3 then 1;
//    best_setting=1, best_err_count=2, done rises exactly 45 edges after start.
//  2 errors {4,4,1,1} -> ties keep lower index: best_setting=2, best_err_count=1.
//  3 err high every cycle during SETTLE only, zero in MEASURE -> all counts 0, best_setting=0.
//  4 ERR_CNT_WIDTH=3, err stuck high -> counts saturate at 7, best_setting=0, best_err_count=7.
//  5 rst pulse during MEASURE of setting 2 -> next cycle IDLE, tx_setting=0, busy=0, done=0;
//    second start pulse mid-sweep in other run -> no restart, timing unchanged.
//  6 in DONE (best=1) manual_en=1, manual_setting=3 -> tx_setting=3 next cycle; start ignored;
//    manual_en=0 -> tx_setting=1 next cycle.

Source files
------------

// File: rtl/tx_ffe_tuner.sv
// tx_ffe_tuner: sweeps every TX FFE tap setting, lets each one settle, counts
// receiver error strobes over a dwell window and applies the setting with the
// fewest errors. A manual override drives tx_setting while the tuner is idle.
module tx_ffe_tuner #(
    parameter int TX_SETTING_WIDTH = 4,
    parameter int N_SETTINGS       = 16,
    parameter int SETTLE_CYCLES    = 64,
    parameter int DWELL_CYCLES     = 1024,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        manual_en,
    input  logic [TX_SETTING_WIDTH-1:0] manual_setting,
    input  logic                        err,
    output logic [TX_SETTING_WIDTH-1:0] tx_setting,
    output logic                        busy,
    output logic                        done,
    output logic [TX_SETTING_WIDTH-1:0] best_setting,
    output logic [ERR_CNT_WIDTH-1:0]    best_err_count
);

    // One phase counter serves both the settle and the dwell window.
    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]            SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]            DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [TX_SETTING_WIDTH-1:0] SETTING_LAST = TX_SETTING_WIDTH'(N_SETTINGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [TX_SETTING_WIDTH-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [TX_SETTING_WIDTH-1:0] tx_q, tx_d;
    logic [TX_SETTING_WIDTH-1:0] best_setting_q, best_setting_d;
    logic [ERR_CNT_WIDTH-1:0]    best_err_q, best_err_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    // Next-state and next-output decode for the sweep sequencer.
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        cur_d          = cur_q;
        cnt_d          = cnt_q;
        err_cnt_d      = err_cnt_q;
        tx_d           = tx_q;
        best_setting_d = best_setting_q;
        best_err_d     = best_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !manual_en) begin
                    state_d        = S_SETTLE;
                    cur_d          = '0;
                    cnt_d          = '0;
                    err_cnt_d      = '0;
                    tx_d           = '0;
                    best_setting_d = '0;
                    best_err_d     = '1;
                end else if (manual_en) begin
                    tx_d = manual_setting;
                end else if (state_q == S_DONE) begin
                    // Leaving manual mode after a sweep restores the tuned value;
                    // in IDLE there is no tuned value, so the last one is held.
                    tx_d = best_setting_q;
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d   = S_MEASURE;
                    cnt_d     = '0;
                    err_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_MEASURE: begin
                if (err && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                end
                if (cnt_q == DWELL_LAST) begin
                    state_d = S_COMPARE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_COMPARE: begin
                // Strict less-than: on a tie the lower setting, seen first, wins.
                if (err_cnt_q < best_err_q) begin
                    best_setting_d = cur_q;
                    best_err_d     = err_cnt_q;
                end
                if (cur_q == SETTING_LAST) begin
                    state_d = S_APPLY;
                end else begin
                    state_d = S_SETTLE;
                    cur_d   = cur_q + TX_SETTING_WIDTH'(1);
                    tx_d    = cur_q + TX_SETTING_WIDTH'(1);
                end
            end

            S_APPLY: begin
                tx_d    = best_setting_q;
                state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                 (state_d == S_COMPARE) || (state_d == S_APPLY);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of statement order.
        if (rst) begin
            state_q        <= S_IDLE;
            cur_q          <= '0;
            cnt_q          <= '0;
            err_cnt_q      <= '0;
            tx_q           <= '0;
            best_setting_q <= '0;
            best_err_q     <= '1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            cnt_q          <= cnt_d;
            err_cnt_q      <= err_cnt_d;
            tx_q           <= tx_d;
            best_setting_q <= best_setting_d;
            best_err_q     <= best_err_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign tx_setting     = tx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign best_setting   = best_setting_q;
    assign best_err_count = best_err_q;

endmodule

// File: tb/tb_tx_ffe_tuner.sv
// tb_tx_ffe_tuner: directed bench for tx_ffe_tuner with N_SETTINGS=4,
// SETTLE_CYCLES=2, DWELL_CYCLES=8. A second instance with a 3-bit error
// counter shares the stimulus and is examined for saturation.
module tb_tx_ffe_tuner;

    localparam int TW  = 4;
    localparam int N   = 4;
    localparam int S   = 2;
    localparam int D   = 8;
    localparam int EW  = 4;
    localparam int EWS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          manual_en;
    logic [TW-1:0] manual_setting;
    logic          err;

    logic [TW-1:0]  tx_setting, best_setting;
    logic           busy, done;
    logic [EW-1:0]  best_err_count;

    logic [TW-1:0]  tx_setting_s, best_setting_s;
    logic           busy_s, done_s;
    logic [EWS-1:0] best_err_count_s;

    int checks   = 0;
    int failures = 0;

    tx_ffe_tuner #(
        .TX_SETTING_WIDTH(TW), .N_SETTINGS(N), .SETTLE_CYCLES(S),
        .DWELL_CYCLES(D), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .manual_en(manual_en),
        .manual_setting(manual_setting), .err(err),
        .tx_setting(tx_setting), .busy(busy), .done(done),
        .best_setting(best_setting), .best_err_count(best_err_count)
    );

    tx_ffe_tuner #(
        .TX_SETTING_WIDTH(TW), .N_SETTINGS(N), .SETTLE_CYCLES(S),
        .DWELL_CYCLES(D), .ERR_CNT_WIDTH(EWS)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .manual_en(manual_en),
        .manual_setting(manual_setting), .err(err),
        .tx_setting(tx_setting_s), .busy(busy_s), .done(done_s),
        .best_setting(best_setting_s), .best_err_count(best_err_count_s)
    );

    // Free-running clock; inputs change and outputs are sampled on negedges.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full sweep: start pulse, then per setting S settle cycles, D measure
    // cycles carrying cN error strobes, and one compare cycle. poke_at re-asserts
    // start at that edge; rst_at fires a reset at that edge and abandons the sweep.
    task automatic sweep(input string name, input int c0, input int c1, input int c2,
                         input int c3, input bit settle_err, input bit stuck,
                         input int poke_at, input int rst_at,
                         input int exp_best, input int exp_err);
        int cnt[4];
        int e;
        cnt = '{c0, c1, c2, c3};
        @(negedge clk);
        start = 1'b1;
        err   = stuck;
        @(negedge clk);
        start = 1'b0;
        check({name, ":start_busy"}, busy, 1);
        check({name, ":start_tx"}, tx_setting, 0);
        check({name, ":start_best_err"}, best_err_count, 15);
        e = 1;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k <= S + D; k++) begin
                if (stuck)          err = 1'b1;
                else if (k < S)     err = settle_err;
                else if (k < S + D) err = ((k - S) < cnt[s]);
                else                err = 1'b0;
                start = (e == poke_at);
                rst   = (e == rst_at);
                @(negedge clk);
                if (e == rst_at) begin
                    rst   = 1'b0;
                    start = 1'b0;
                    err   = 1'b0;
                    return;
                end
                if (k == S + D / 2) begin
                    check($sformatf("%s:tx_in_measure_%0d", name, s), tx_setting, s);
                    check($sformatf("%s:busy_in_measure_%0d", name, s), busy, 1);
                end
                e++;
            end
        end
        start = 1'b0;
        err   = 1'b0;
        // Edge 44 after start: APPLY, still busy.
        check({name, ":done_at_44"}, done, 0);
        check({name, ":busy_at_44"}, busy, 1);
        check({name, ":tx_at_44"}, tx_setting, N - 1);
        @(negedge clk);
        // Edge 45 after start: DONE with the winner applied.
        check({name, ":done_at_45"}, done, 1);
        check({name, ":busy_at_45"}, busy, 0);
        check({name, ":best_setting"}, best_setting, exp_best);
        check({name, ":best_err"}, best_err_count, exp_err);
        check({name, ":tx_applied"}, tx_setting, exp_best);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        manual_en      = 1'b0;
        manual_setting = '0;
        err            = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        check("rst:tx", tx_setting, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:best_setting", best_setting, 0);
        check("rst:best_err", best_err_count, 15);
        check("rst:best_err_sat", best_err_count_s, 7);

        // IDLE manual override: start ignored, tx follows manual, then held.
        manual_en      = 1'b1;
        manual_setting = 4'd5;
        start          = 1'b1;
        @(negedge clk);
        check("idle_man:busy", busy, 0);
        check("idle_man:tx", tx_setting, 5);
        manual_en = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("idle_man:tx_hold", tx_setting, 5);

        // Sweep with distinct counts.
        sweep("t1", 5, 2, 7, 3, 1'b0, 1'b0, -1, -1, 1, 2);

        // DONE manual override, start ignored, then restore tuned value.
        manual_en      = 1'b1;
        manual_setting = 4'd3;
        start          = 1'b1;
        @(negedge clk);
        check("t6:tx_manual", tx_setting, 3);
        check("t6:done", done, 1);
        check("t6:busy", busy, 0);
        @(negedge clk);
        check("t6:busy_start_ignored", busy, 0);
        manual_en = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("t6:tx_restored", tx_setting, 1);
        check("t6:done_held", done, 1);

        // Ties keep the lower index; a start pulse mid-sweep must not restart.
        sweep("t2", 4, 4, 1, 1, 1'b0, 1'b0, 15, -1, 2, 1);

        // Errors only during settle windows are not counted.
        sweep("t3", 0, 0, 0, 0, 1'b1, 1'b0, -1, -1, 0, 0);

        // Error stuck high: 8 per setting, and the 3-bit instance saturates.
        sweep("t4", 0, 0, 0, 0, 1'b0, 1'b1, -1, -1, 0, 8);
        check("t4:sat_done", done_s, 1);
        check("t4:sat_best_setting", best_setting_s, 0);
        check("t4:sat_best_err", best_err_count_s, 7);

        // Reset during MEASURE of setting 2 aborts immediately.
        sweep("t5", 3, 1, 1, 1, 1'b0, 1'b0, -1, 28, 0, 0);
        check("t5:busy", busy, 0);
        check("t5:done", done, 0);
        check("t5:tx", tx_setting, 0);
        check("t5:best_setting", best_setting, 0);
        check("t5:best_err", best_err_count, 15);
        repeat (3) @(negedge clk);
        check("t5:stays_idle", busy, 0);
        check("t5:no_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
